// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and widths for the SR flop command generator.
package sr_cmd_pkg;

    localparam int SR_CMD_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } sr_cmd_state_t;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request handshake carrying the target q level into the command generator.
interface sr_cmd_gen_if;
    logic req_valid;
    logic req_data;
    logic req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/sr_cmd_gen_timer.sv
// Loadable down-counter shared by the pulse-width and idle-gap phases.
module sr_pulse_timer
    import sr_cmd_pkg::*;
(
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    load,
    input  logic [SR_CMD_CNT_W-1:0] load_val,
    output logic                    zero
);

    logic [SR_CMD_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sr_cmd_gen.sv
// Converts target-level requests into single width-controlled S or R pulses,
// with a guaranteed idle gap and a q feedback check after each pulse.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic                    clk,
    input  logic                    clear,
    sr_cmd_gen_if.slave             req,
    input  logic                    q_fb,
    input  logic                    err_clr,
    output logic                    s,
    output logic                    r,
    output logic                    q_track,
    output logic                    err,
    output logic [SR_CMD_CNT_W-1:0] pulse_cnt
);

    localparam logic [SR_CMD_CNT_W-1:0] PULSE_LD = SR_CMD_CNT_W'(PULSE_W - 1);
    localparam logic [SR_CMD_CNT_W-1:0] GAP_LD   = SR_CMD_CNT_W'(GAP_W - 1);

    sr_cmd_state_t           state;
    logic                    target;
    logic                    accept;
    logic                    fire;
    logic                    tmr_load;
    logic [SR_CMD_CNT_W-1:0] tmr_val;
    logic                    tmr_zero;
    logic                    gap_end;

    assign req.req_ready = (state == IDLE);
    assign accept        = req.req_valid && (state == IDLE);
    // A request matching the tracked level is consumed without a pulse.
    assign fire          = accept && (req.req_data != q_track);
    assign tmr_load      = fire || ((state == PULSE) && tmr_zero);
    assign tmr_val       = (state == IDLE) ? PULSE_LD : GAP_LD;
    assign gap_end       = (state == GAP) && tmr_zero;

    sr_pulse_timer u_timer (
        .clk      (clk),
        .clear    (clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            s         <= 1'b0;
            r         <= 1'b0;
            target    <= 1'b0;
            q_track   <= 1'b0;
            err       <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state  <= PULSE;
                        s      <= req.req_data;
                        r      <= !req.req_data;
                        target <= req.req_data;
                    end
                end
                PULSE: begin
                    if (tmr_zero) begin
                        state     <= GAP;
                        s         <= 1'b0;
                        r         <= 1'b0;
                        q_track   <= target;
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                end
            endcase

            // A fresh mismatch outranks a simultaneous clear request.
            if (gap_end && (q_fb != q_track)) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed self-checking bench for sr_cmd_gen with PULSE_W=2, GAP_W=1.
module tb_sr_cmd_gen;

    logic       clk;
    logic       clear;
    logic       q_fb;
    logic       err_clr;
    logic       s;
    logic       r;
    logic       q_track;
    logic       err;
    logic [7:0] pulse_cnt;

    int checks   = 0;
    int failures = 0;

    sr_cmd_gen_if req_if ();

    sr_cmd_gen #(.PULSE_W(2), .GAP_W(1)) dut (
        .clk       (clk),
        .clear     (clear),
        .req       (req_if),
        .q_fb      (q_fb),
        .err_clr   (err_clr),
        .s         (s),
        .r         (r),
        .q_track   (q_track),
        .err       (err),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, settle, and confirm S and R never overlap.
    task automatic step();
        @(posedge clk);
        #1;
        check("s_and_r_exclusive", {31'd0, s & r}, 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic e_s, input logic e_r,
                              input logic e_q, input logic e_err,
                              input logic [7:0] e_cnt, input logic e_rdy);
        check({tag, ".s"},         {31'd0, s},                 {31'd0, e_s});
        check({tag, ".r"},         {31'd0, r},                 {31'd0, e_r});
        check({tag, ".q_track"},   {31'd0, q_track},           {31'd0, e_q});
        check({tag, ".err"},       {31'd0, err},               {31'd0, e_err});
        check({tag, ".pulse_cnt"}, {24'd0, pulse_cnt},         {24'd0, e_cnt});
        check({tag, ".req_ready"}, {31'd0, req_if.req_ready},  {31'd0, e_rdy});
    endtask

    initial begin
        logic       d;
        logic [7:0] exp_cnt;

        clear            = 1'b1;
        req_if.req_valid = 1'b0;
        req_if.req_data  = 1'b0;
        q_fb             = 1'b0;
        err_clr          = 1'b0;

        // Reset
        step();
        step();
        check("rst_hold.s", {31'd0, s}, 32'd0);
        check("rst_hold.r", {31'd0, r}, 32'd0);
        clear = 1'b0;
        step();
        expect_out("reset", 0, 0, 0, 0, 8'd0, 1);

        // Reset one cycle into an S pulse
        req_if.req_valid = 1'b1;
        req_if.req_data  = 1'b1;
        step();
        expect_out("midrst_pre", 1, 0, 0, 0, 8'd0, 0);
        clear = 1'b1;
        #1;
        expect_out("midrst_async", 0, 0, 0, 0, 8'd0, 1);
        step();
        expect_out("midrst_held", 0, 0, 0, 0, 8'd0, 1);
        req_if.req_valid = 1'b0;
        clear            = 1'b0;
        step();
        expect_out("midrst_after", 0, 0, 0, 0, 8'd0, 1);

        // Set pulse from q_track=0, q_fb follows
        req_if.req_valid = 1'b1;
        req_if.req_data  = 1'b1;
        step();
        expect_out("set_e0", 1, 0, 0, 0, 8'd0, 0);
        req_if.req_valid = 1'b0;
        q_fb             = 1'b1;
        step();
        expect_out("set_e1", 1, 0, 0, 0, 8'd0, 0);
        step();
        expect_out("set_e2", 0, 0, 1, 0, 8'd1, 0);
        step();
        expect_out("set_e3", 0, 0, 1, 0, 8'd1, 1);

        // Redundant request
        req_if.req_valid = 1'b1;
        req_if.req_data  = 1'b1;
        step();
        expect_out("redund", 0, 0, 1, 0, 8'd1, 1);
        req_if.req_valid = 1'b0;
        step();
        expect_out("redund_after", 0, 0, 1, 0, 8'd1, 1);

        // R pulse with q_fb stuck at 1 -> mismatch
        req_if.req_valid = 1'b1;
        req_if.req_data  = 1'b0;
        step();
        expect_out("mis_e0", 0, 1, 1, 0, 8'd1, 0);
        req_if.req_valid = 1'b0;
        step();
        expect_out("mis_e1", 0, 1, 1, 0, 8'd1, 0);
        step();
        expect_out("mis_e2", 0, 0, 0, 0, 8'd2, 0);
        step();
        expect_out("mis_e3", 0, 0, 0, 1, 8'd2, 1);

        // S pulse with q_fb stuck at 0, err_clr on the mismatch edge
        q_fb             = 1'b0;
        req_if.req_valid = 1'b1;
        req_if.req_data  = 1'b1;
        step();
        expect_out("mis2_e0", 1, 0, 0, 1, 8'd2, 0);
        req_if.req_valid = 1'b0;
        step();
        step();
        expect_out("mis2_e2", 0, 0, 1, 1, 8'd3, 0);
        err_clr = 1'b1;
        step();
        expect_out("mis2_clr_tie", 0, 0, 1, 1, 8'd3, 1);
        step();
        expect_out("err_clr_alone", 0, 0, 1, 0, 8'd3, 1);
        err_clr = 1'b0;
        step();
        expect_out("err_stays_clr", 0, 0, 1, 0, 8'd3, 1);

        // Stream of alternating requests, 260 pulses -> count wraps to 4
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        expect_out("stream_rst", 0, 0, 0, 0, 8'd0, 1);
        exp_cnt          = 8'd0;
        req_if.req_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            d               = (i % 2 == 0) ? 1'b1 : 1'b0;
            req_if.req_data = d;
            q_fb            = d;
            step();
            check("stream.s_e0",   {31'd0, s}, {31'd0, d});
            check("stream.r_e0",   {31'd0, r}, {31'd0, !d});
            check("stream.rdy_e0", {31'd0, req_if.req_ready}, 32'd0);
            step();
            check("stream.s_e1", {31'd0, s}, {31'd0, d});
            check("stream.r_e1", {31'd0, r}, {31'd0, !d});
            step();
            exp_cnt = exp_cnt + 8'd1;
            expect_out("stream_e2", 0, 0, d, 0, exp_cnt, 0);
            step();
            check("stream.rdy_e3", {31'd0, req_if.req_ready}, 32'd1);
            if (i == 3) begin
                check("stream.cnt4", {24'd0, pulse_cnt}, 32'd4);
            end
        end
        req_if.req_valid = 1'b0;
        step();
        expect_out("stream_end", 0, 0, 0, 0, 8'd4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
